// File: rtl/serial_adder_if.sv
// ============================================================================
// serial_adder_if : operand/result valid-ready bundle for serial_adder. Rev 1.0
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : bit-serial WIDTH-bit adder sequencing one fulladd cell. Rev 1.0
// ============================================================================
`default_nettype none

module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_s_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_fa_s;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_s_next;
    logic               w_last;

    fulladd u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    // Sum bits enter at the top and migrate down, so after WIDTH steps bit 0 sits at LSB.
    assign w_s_next = {w_fa_s, r_s_sh};
    assign w_last   = (r_cnt == c_last_cnt);

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_s_sh  <= w_s_next[WIDTH-1:1];
                    r_carry <= w_fa_cout;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_sum  <= w_s_next;
                        r_cout <= w_fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16. Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic rst16_n;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(16)) bus16 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst16_n),
        .bus   (bus16)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    int issued8 = 0, done8 = 0, issued16 = 0, done16 = 0;
    int rmode8  = 0, rmode16 = 0;   // out_ready: 0 always high, 1 random, 2 held low
    int ov_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus8.out_ready  = (rmode8 == 0)  ? 1'b1 : (rmode8 == 1)  ? 1'($urandom_range(0, 1)) : 1'b0;
            bus16.out_ready = (rmode16 == 0) ? 1'b1 : (rmode16 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Result monitors: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus8.out_valid) begin
            if (q8.size() == 0) flag("spurious_result8");
            else if (bus8.out_ready) begin
                chk("result8", {bus8.cout, bus8.sum}, q8.pop_front());
                done8++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst16_n && bus16.out_valid) begin
            if (q16.size() == 0) flag("spurious_result16");
            else if (bus16.out_ready) begin
                chk("result16", {bus16.cout, bus16.sum}, q16.pop_front());
                done16++;
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b1;
        bus8.a        = a;
        bus8.b        = b;
        bus8.cin      = c;
        @(negedge clk);
        while (!bus8.in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!bus8.in_ready) flag("send8_timeout");
        else if (push) begin
            q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
            issued8++;
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b1;
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = c;
        @(negedge clk);
        while (!bus16.in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!bus16.in_ready) flag("send16_timeout");
        else begin
            q16.push_back({1'b0, a} + {1'b0, b} + 17'(c));
            issued16++;
        end
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        @(negedge clk);
        while ((q8.size() != 0 || !bus8.in_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (q8.size() != 0 || !bus8.in_ready) flag("wait_idle8_timeout");
    endtask

    task automatic wait_idle16();
        int t;
        t = 0;
        @(negedge clk);
        while ((q16.size() != 0 || !bus16.in_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (q16.size() != 0 || !bus16.in_ready) flag("wait_idle16_timeout");
    endtask

    task automatic chk_reset8(input string name);
        chk({name, "_in_ready"},  bus8.in_ready,  1'b1);
        chk({name, "_out_valid"}, bus8.out_valid, 1'b0);
        chk({name, "_busy"},      bus8.busy,      1'b0);
        chk({name, "_sum"},       bus8.sum,       8'h00);
        chk({name, "_cout"},      bus8.cout,      1'b0);
    endtask

    initial begin
        int t;
        rst_n          = 1'b0;
        rst16_n        = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.cin       = 1'b0;
        bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0;
        bus16.a        = '0;
        bus16.b        = '0;
        bus16.cin      = 1'b0;
        bus16.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset8("por");
        @(negedge clk);
        rst_n   = 1'b1;
        rst16_n = 1'b1;

        // Basic add with exact latency: busy for 8 cycles, then out_valid.
        send8(8'h0F, 8'h01, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("run_busy_valid", {bus8.busy, bus8.out_valid}, 2'b10);
        end
        @(negedge clk);
        chk("done_busy_valid_ready", {bus8.busy, bus8.out_valid, bus8.in_ready}, 3'b010);
        wait_idle8();
        chk("idle_keeps_sum", {bus8.cout, bus8.sum}, 9'h010);

        // Asynchronous reset mid-cycle, observed before any clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset8("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        send8(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_idle8();
        send8(8'hFF, 8'hFF, 1'b1, 1'b1);
        wait_idle8();
        send8(8'h00, 8'h00, 1'b1, 1'b1);
        wait_idle8();

        // Backpressure: result held, new operands ignored.
        rmode8 = 2;
        send8(8'h5A, 8'h33, 1'b0, 1'b1);
        t = 0;
        while (!bus8.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus8.out_valid) flag("bp_no_result");
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            bus8.in_valid = 1'b1;
            bus8.a        = 8'h11;
            bus8.b        = 8'h00;
            bus8.cin      = 1'b0;
            @(negedge clk);
            chk("bp_hold", {bus8.out_valid, bus8.in_ready, bus8.cout, bus8.sum}, 11'h48D);
        end
        @(posedge clk);
        #1;
        bus8.in_valid  = 1'b0;
        rmode8         = 0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", {bus8.in_ready, bus8.out_valid, bus8.busy}, 3'b100);

        // Reset during RUN discards the operation.
        send8(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_run_busy", bus8.busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset8("mid_run_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.out_valid) ov_seen++;
        end
        chk("no_partial_result", ov_seen, 0);
        send8(8'h01, 8'h02, 1'b0, 1'b1);
        wait_idle8();

        // Randomised traffic on both widths concurrently.
        rmode8  = 1;
        rmode16 = 1;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
                end
            end
            begin
                for (int j = 0; j < 500; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                end
            end
        join
        wait_idle8();
        wait_idle16();
        rmode8  = 0;
        rmode16 = 0;

        chk("count8",  done8,  issued8);
        chk("count16", done16, issued16);
        chk("issued16", issued16, 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

`default_nettype wire
